riscv_register_file_mp: RTL and testbench
=========================================

Name: riscv_register_file_mp

Overview:
Parametrised multi-port successor of the integer/FP register file for the RI5CY-class core.
- Provides NUM_READ combinational read ports and NUM_WRITE prioritised write ports.
- Integer bank with R0 hard-wired to zero; optional FP bank when FPU=1 and Zfinx=0.
- Adds a per-register busy scoreboard for long-latency writeback.
- Adds a hardware scrub FSM that zeroes the whole file on request, for context switches.
- Sits in the ID stage; ID and dispatch logic drive the read ports, WB and LSU drive the write ports.

Parameters:
ADDR_WIDTH, 6, address width; MSB selects the FP bank when FPU=1.
DATA_WIDTH, 32, register width.
NUM_READ, 3, number of read ports (at least 1).
NUM_WRITE, 2, number of write ports (at least 1); the higher index has higher priority.
FPU, 0, 1 instantiates the FP bank.
Zfinx, 0, 1 suppresses the FP bank even when FPU=1.

Ports:
clk  in  1  clock
rst_n  in  1  reset; one clock, reset is asynchronous and active-low
raddr_i  in  NUM_READ*ADDR_WIDTH  read addresses, packed; port k in slice k
rdata_o  out  NUM_READ*DATA_WIDTH  read data
rbusy_o  out  NUM_READ  scoreboard busy bit of each read address
waddr_i  in  NUM_WRITE*ADDR_WIDTH  write addresses
wdata_i  in  NUM_WRITE*DATA_WIDTH  write data
we_i  in  NUM_WRITE  write enables
rsv_we_i  in  1  reserve request: mark rsv_addr_i busy
rsv_addr_i  in  ADDR_WIDTH  register to reserve
scrub_req_i  in  1  start scrub (level-sampled in IDLE)
scrub_busy_o  out  1  high while scrub is active; core must stall
scrub_done_o  out  1  one-cycle pulse when scrub completes

Behaviour:
- Storage size: NUM_WORDS = 2**(ADDR_WIDTH-1). NUM_TOT = 2*NUM_WORDS if FPU=1 and Zfinx=0, else NUM_WORDS.
- Address decode: address MSB=1 selects the FP bank only when the FP bank exists; otherwise the MSB is ignored.
- Reset: all registers 0, all busy bits 0, FSM in IDLE, scrub_busy_o=0, scrub_done_o=0.
- Read: combinational, zero latency; rdata[k] = mem[raddr[k]].
  - Integer R0 always reads 0 and rbusy=0.
  - FP register 0 is a normal register.
- Write: takes effect at posedge.
  - Writes to integer R0 are dropped.
  - Several ports writing the same address in one cycle: the highest-index enabled port wins.
  - Every accepted write clears the target's busy bit.
- Reserve: rsv_we_i sets busy[rsv_addr_i] at posedge; R0 is ignored.
  - Reserve and write to the same address in one cycle: busy ends at 1, data is written (the new producer wins).
- Scrub FSM:
  - IDLE: scrub_req_i=1 -> SCRUB; counter loads 0.
  - SCRUB: each cycle zeroes mem[cnt] and busy[cnt], then cnt++. When cnt==NUM_TOT-1 -> DONE.
  - SCRUB duration is exactly NUM_TOT cycles.
  - scrub_busy_o=1 in SCRUB and DONE.
  - DONE: scrub_done_o=1 for one cycle, then -> IDLE.
  - During SCRUB and DONE, all port writes and reserves are ignored and scrub_req_i is ignored. Reads stay functional and return partially-scrubbed contents.
- rst_n asserted mid-scrub: FSM returns to IDLE immediately, no done pulse; the file is zero through reset.

Optional Feature:
Macro RF_BYPASS_EN.
- Defined: read port k returns the winning write data this cycle if an accepted write targets raddr[k] (same-cycle write-to-read forwarding). rbusy[k] reads 0 in that case unless a reserve to the same address occurs in the same cycle. Bypass is disabled during SCRUB.
- Undefined: reads return the stored value only; the new value is visible the next cycle.

Decomposition:
- Package riscv_rf_pkg holds:
  - scrub_state_e enum {IDLE, SCRUB, DONE}.
  - Function rf_num_tot(ADDR_WIDTH, FPU, Zfinx).
  - Localparam RF_ZERO_ADDR=0.
- Sub-module riscv_rf_wdec: one-hot write-enable decoder with port priority. Outputs are a per-register enable and the winning port index. It is shared by the write path and the bypass path.

Test Plan:
- Priority: we_i=2'b11, both to x5, wdata port0=0x11, port1=0x22 -> next cycle x5 reads 0x22 and rbusy for x5=0.
- R0: write 0xDEAD to x0 with rsv_we_i on x0 -> rdata=0, rbusy=0.
- Scoreboard: reserve x7 at cycle 0 -> rbusy=1 from cycle 1. Write x7=0x5 with a same-cycle reserve of x7 -> data=0x5, rbusy stays 1. A later write alone -> rbusy=0.
- Scrub: fill all registers with 0xA5A5A5A5, pulse scrub_req_i (FPU=1, ADDR_WIDTH=6, NUM_TOT=64).
  - scrub_busy_o high 65 cycles; scrub_done_o pulses on the 65th.
  - Writes during that window are ignored; all reads then return 0.
- Reset mid-scrub: assert rst_n=0 at scrub cycle 10 -> FSM IDLE, no done pulse, all regs 0, scrub_busy_o=0.
- RF_BYPASS_EN: write x3=0x1234 while reading x3 in the same cycle -> rdata=0x1234 with the macro, old value without it.

Source files
------------

// File: rtl/riscv_rf_pkg.sv
// Shared types and helpers for the multi-port register file.
// Holds the scrub FSM state type, the storage-size helper and the
// hard-wired-zero register address.
package riscv_rf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCRUB = 2'd1,
    DONE  = 2'd2
  } scrub_state_e;

  localparam int RF_ZERO_ADDR = 0;

  // Total number of physical registers: the integer bank, plus the FP bank
  // when an FPU is present and FP values do not live in integer registers.
  function automatic int rf_num_tot(input int addr_width, input int fpu, input int zfinx);
    int words;
    words = 1 << (addr_width - 1);
    return ((fpu == 1) && (zfinx == 0)) ? 2 * words : words;
  endfunction

endpackage

// File: rtl/riscv_rf_wdec.sv
// Write-enable decoder with port priority.
// Turns the packed write ports into one enable per physical register and
// records which port won each register. When several enabled ports hit the
// same register, the highest-index port wins. Writes to integer R0 never
// produce an enable. The same outputs feed the storage update and the
// optional same-cycle read forwarding, so both always agree on the winner.
module riscv_rf_wdec
  import riscv_rf_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_WRITE  = 2,
  parameter int IDX_W      = 5,
  parameter int NUM_TOT    = 32,
  parameter int WP_W       = 1
) (
  input  logic                                en_i,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0]     waddr_i,
  input  logic [NUM_WRITE-1:0]                we_i,
  output logic [NUM_TOT-1:0]                  reg_we_o,
  output logic [NUM_TOT-1:0][WP_W-1:0]        win_port_o
);

  logic [IDX_W-1:0] widx;

  // Scan ports low to high so a later (higher-priority) port overrides.
  always_comb begin
    reg_we_o   = '0;
    win_port_o = '0;
    widx       = '0;
    for (int p = 0; p < NUM_WRITE; p++) begin
      widx = IDX_W'(waddr_i[p*ADDR_WIDTH +: ADDR_WIDTH]);
      if (en_i && we_i[p] && (widx != IDX_W'(RF_ZERO_ADDR))) begin
        reg_we_o[widx]   = 1'b1;
        win_port_o[widx] = WP_W'(p);
      end
    end
  end

endmodule

// File: rtl/riscv_register_file_mp.sv
// Multi-port integer/FP register file with busy scoreboard and scrub FSM.
// Reads are combinational; writes, reserves and scrub steps land at posedge.
// Handshake: there is no valid/ready pair here; scrub_req_i is a level that is
// only looked at in IDLE, and while scrub_busy_o is high the core must stall
// because port writes and reserves are dropped.
// Optional macro RF_BYPASS_EN: same-cycle write-to-read forwarding.
module riscv_register_file_mp
  import riscv_rf_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_READ   = 3,
  parameter int NUM_WRITE  = 2,
  parameter int FPU        = 0,
  parameter int Zfinx      = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]  raddr_i,
  output logic [NUM_READ*DATA_WIDTH-1:0]  rdata_o,
  output logic [NUM_READ-1:0]             rbusy_o,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0] waddr_i,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0] wdata_i,
  input  logic [NUM_WRITE-1:0]            we_i,
  input  logic                            rsv_we_i,
  input  logic [ADDR_WIDTH-1:0]           rsv_addr_i,
  input  logic                            scrub_req_i,
  output logic                            scrub_busy_o,
  output logic                            scrub_done_o
);

  // Without an FP bank the address MSB is simply dropped by the index width.
  localparam bit HAS_FP  = (FPU == 1) && (Zfinx == 0);
  localparam int NUM_TOT = rf_num_tot(ADDR_WIDTH, FPU, Zfinx);
  localparam int IDX_W   = HAS_FP ? ADDR_WIDTH : ADDR_WIDTH - 1;
  localparam int WP_W    = (NUM_WRITE > 1) ? $clog2(NUM_WRITE) : 1;

  scrub_state_e                   scrub_state;
  scrub_state_e                   scrub_state_d;
  logic [IDX_W-1:0]               cnt_q;
  logic                           last_cnt;

  logic [DATA_WIDTH-1:0]          mem [NUM_TOT];
  logic [NUM_TOT-1:0]             busy_q;

  logic                           port_en;
  logic [NUM_TOT-1:0]             reg_we;
  logic [NUM_TOT-1:0][WP_W-1:0]   win_port;
  logic [IDX_W-1:0]               rsv_idx;
  logic                           rsv_hit;
  logic [IDX_W-1:0]               ridx;

  // Ports only act while the scrubber is idle.
  assign port_en  = (scrub_state == IDLE);
  assign rsv_idx  = IDX_W'(rsv_addr_i);
  assign rsv_hit  = port_en && rsv_we_i && (rsv_idx != IDX_W'(RF_ZERO_ADDR));
  assign last_cnt = (cnt_q == IDX_W'(NUM_TOT - 1));

  riscv_rf_wdec #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_WRITE  (NUM_WRITE),
    .IDX_W      (IDX_W),
    .NUM_TOT    (NUM_TOT),
    .WP_W       (WP_W)
  ) u_wdec (
    .en_i       (port_en),
    .waddr_i    (waddr_i),
    .we_i       (we_i),
    .reg_we_o   (reg_we),
    .win_port_o (win_port)
  );

  // Scrub FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) scrub_state <= IDLE;
    else        scrub_state <= scrub_state_d;
  end

  // Scrub FSM next state: one SCRUB cycle per register, then one DONE cycle.
  always_comb begin
    scrub_state_d = scrub_state;
    case (scrub_state)
      IDLE:    if (scrub_req_i) scrub_state_d = SCRUB;
      SCRUB:   if (last_cnt)    scrub_state_d = DONE;
      DONE:    scrub_state_d = IDLE;
      default: scrub_state_d = IDLE;
    endcase
  end

  // Scrub FSM outputs.
  always_comb begin
    scrub_busy_o = (scrub_state == SCRUB) || (scrub_state == DONE);
    scrub_done_o = (scrub_state == DONE);
  end

  // Scrub pointer: held at 0 outside SCRUB, steps once per SCRUB cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    cnt_q <= '0;
    else if (scrub_state == SCRUB) cnt_q <= cnt_q + IDX_W'(1);
    else                           cnt_q <= '0;
  end

  // Storage and scoreboard update: scrub step, else port writes and reserves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_TOT; r++) mem[r] <= '0;
      busy_q <= '0;
    end else if (scrub_state == SCRUB) begin
      mem[cnt_q]    <= '0;
      busy_q[cnt_q] <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_TOT; r++) begin
        if (reg_we[r]) mem[r] <= wdata_i[win_port[r]*DATA_WIDTH +: DATA_WIDTH];
        // A same-cycle reserve names a newer producer, so it beats the clear.
        if (rsv_hit && (rsv_idx == IDX_W'(r))) busy_q[r] <= 1'b1;
        else if (reg_we[r])                    busy_q[r] <= 1'b0;
      end
    end
  end

  // Combinational read ports; integer R0 reads as zero and never busy.
  always_comb begin
    rdata_o = '0;
    rbusy_o = '0;
    ridx    = '0;
    for (int k = 0; k < NUM_READ; k++) begin
      ridx = IDX_W'(raddr_i[k*ADDR_WIDTH +: ADDR_WIDTH]);
      if (ridx != IDX_W'(RF_ZERO_ADDR)) begin
        rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = mem[ridx];
        rbusy_o[k]                          = busy_q[ridx];
`ifdef RF_BYPASS_EN
        // reg_we is already gated off while scrubbing, so no forwarding then.
        if (reg_we[ridx]) begin
          rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = wdata_i[win_port[ridx]*DATA_WIDTH +: DATA_WIDTH];
          rbusy_o[k]                          = rsv_hit && (rsv_idx == ridx);
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_riscv_register_file_mp.sv
// Directed self-checking bench for riscv_register_file_mp (FPU=1, 64 registers).
module tb_riscv_register_file_mp;

  localparam int AW = 6;
  localparam int DW = 32;
  localparam int NR = 3;
  localparam int NW = 2;

  localparam logic [DW-1:0] FILL = 32'hA5A5_A5A5;
`ifdef RF_BYPASS_EN
  localparam logic [DW-1:0] BYP_EXP = 32'h0000_1234;
`else
  localparam logic [DW-1:0] BYP_EXP = 32'h0000_0000;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR*AW-1:0]  raddr;
  logic [NR*DW-1:0]  rdata;
  logic [NR-1:0]     rbusy;
  logic [NW*AW-1:0]  waddr;
  logic [NW*DW-1:0]  wdata;
  logic [NW-1:0]     we;
  logic              rsv_we;
  logic [AW-1:0]     rsv_addr;
  logic              scrub_req;
  logic              scrub_busy;
  logic              scrub_done;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q[$];

  int busy_cnt;
  int done_cnt;
  int done_at;

  riscv_register_file_mp #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_READ   (NR),
    .NUM_WRITE  (NW),
    .FPU        (1),
    .Zfinx      (0)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .raddr_i      (raddr),
    .rdata_o      (rdata),
    .rbusy_o      (rbusy),
    .waddr_i      (waddr),
    .wdata_i      (wdata),
    .we_i         (we),
    .rsv_we_i     (rsv_we),
    .rsv_addr_i   (rsv_addr),
    .scrub_req_i  (scrub_req),
    .scrub_busy_o (scrub_busy),
    .scrub_done_o (scrub_done)
  );

  // Clock
  always #5 clk = ~clk;

  // Checker
  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    we        = '0;
    rsv_we    = 1'b0;
    scrub_req = 1'b0;
  endtask

  task automatic set_rd(input int k, input logic [AW-1:0] a);
    raddr[k*AW +: AW] = a;
  endtask

  task automatic wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    waddr[p*AW +: AW] = a;
    wdata[p*DW +: DW] = d;
    we[p]             = 1'b1;
  endtask

  task automatic rsv(input logic [AW-1:0] a);
    rsv_addr = a;
    rsv_we   = 1'b1;
  endtask

  function automatic logic [DW-1:0] rd(input int k);
    return rdata[k*DW +: DW];
  endfunction

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    raddr    = '0;
    waddr    = '0;
    wdata    = '0;
    rsv_addr = '0;

    // Reset state
    tick();
    set_rd(0, 6'd5);
    #1;
    check("rst_busy", 32'(scrub_busy), 32'd0);
    check("rst_done", 32'(scrub_done), 32'd0);
    check("rst_rdata", rd(0), 32'd0);
    check("rst_rbusy", 32'(rbusy[0]), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Write-port priority, and a write clears an earlier reservation
    rsv(6'd5);
    tick();
    idle_inputs();
    #1;
    check("rsv_x5_busy", 32'(rbusy[0]), 32'd1);
    wr(0, 6'd5, 32'h11);
    wr(1, 6'd5, 32'h22);
    tick();
    idle_inputs();
    #1;
    check("prio_data", rd(0), 32'h22);
    check("prio_rbusy", 32'(rbusy[0]), 32'd0);
    wr(0, 6'd6, 32'h66);
    tick();
    idle_inputs();
    set_rd(1, 6'd6);
    #1;
    check("port0_data", rd(1), 32'h66);

    // R0 ignores writes and reserves
    set_rd(0, 6'd0);
    wr(0, 6'd0, 32'hDEAD);
    rsv(6'd0);
    #1;
    check("r0_same_cycle", rd(0), 32'd0);
    tick();
    idle_inputs();
    #1;
    check("r0_data", rd(0), 32'd0);
    check("r0_rbusy", 32'(rbusy[0]), 32'd0);

    // FP register 0 is a normal register and does not alias x0
    wr(1, 6'd32, 32'hF00);
    tick();
    idle_inputs();
    set_rd(0, 6'd32);
    set_rd(1, 6'd0);
    #1;
    check("f0_data", rd(0), 32'hF00);
    check("x0_after_f0", rd(1), 32'd0);

    // Scoreboard: reserve, write+reserve, plain write
    set_rd(2, 6'd7);
    #1;
    check("x7_free", 32'(rbusy[2]), 32'd0);
    rsv(6'd7);
    tick();
    idle_inputs();
    #1;
    check("x7_rsv_busy", 32'(rbusy[2]), 32'd1);
    wr(0, 6'd7, 32'h5);
    rsv(6'd7);
    #1;
    check("x7_wr_rsv_same", 32'(rbusy[2]), 32'd1);
    tick();
    idle_inputs();
    #1;
    check("x7_wr_rsv_data", rd(2), 32'h5);
    check("x7_wr_rsv_busy", 32'(rbusy[2]), 32'd1);
    wr(1, 6'd7, 32'h9);
    tick();
    idle_inputs();
    #1;
    check("x7_wr_data", rd(2), 32'h9);
    check("x7_wr_busy", 32'(rbusy[2]), 32'd0);

    // Same-cycle read of a register being written
    set_rd(0, 6'd3);
    wr(0, 6'd3, 32'h1234);
    #1;
    check("bypass_same", rd(0), BYP_EXP);
    check("bypass_rbusy", 32'(rbusy[0]), 32'd0);
    tick();
    idle_inputs();
    #1;
    check("bypass_next", rd(0), 32'h1234);

    // Fill every register, then reserve x9
    for (int i = 0; i < 32; i++) begin
      wr(0, AW'(2 * i), FILL);
      wr(1, AW'(2 * i + 1), FILL);
      tick();
    end
    idle_inputs();
    rsv(6'd9);
    tick();
    idle_inputs();
    set_rd(2, 6'd9);
    #1;
    check("x9_busy_pre", 32'(rbusy[2]), 32'd1);
    for (int a = 0; a < 64; a++) exp_q.push_back((a == 0) ? 32'd0 : FILL);
    for (int a = 0; a < 64; a++) begin
      set_rd(0, AW'(a));
      #1;
      check($sformatf("fill_rb_%0d", a), rd(0), exp_q.pop_front());
    end

    // Scrub with writes and reserves attempted throughout
    scrub_req = 1'b1;
    tick();
    scrub_req = 1'b0;
    wr(0, 6'd2, 32'h77);
    rsv(6'd4);
    set_rd(1, 6'd63);
    #1;
    check("scrub_partial", rd(1), FILL);
    busy_cnt = 0;
    done_cnt = 0;
    done_at  = 0;
    for (int c = 0; c < 200; c++) begin
      if (!scrub_busy) break;
      busy_cnt++;
      if (scrub_done) begin
        done_cnt++;
        done_at = busy_cnt;
      end
      tick();
    end
    idle_inputs();
    check("scrub_busy_cycles", 32'(busy_cnt), 32'd65);
    check("scrub_done_pulses", 32'(done_cnt), 32'd1);
    check("scrub_done_cycle", 32'(done_at), 32'd65);
    check("scrub_done_low", 32'(scrub_done), 32'd0);
    for (int a = 0; a < 64; a++) exp_q.push_back(32'd0);
    for (int a = 0; a < 64; a++) begin
      set_rd(0, AW'(a));
      #1;
      check($sformatf("scrub_rb_%0d", a), rd(0), exp_q.pop_front());
    end
    set_rd(0, 6'd4);
    set_rd(2, 6'd9);
    #1;
    check("scrub_x4_busy", 32'(rbusy[0]), 32'd0);
    check("scrub_x9_busy", 32'(rbusy[2]), 32'd0);

    // Reset in the middle of a scrub
    wr(0, 6'd1, 32'hBEEF);
    wr(1, 6'd40, 32'hCAFE);
    tick();
    idle_inputs();
    scrub_req = 1'b1;
    tick();
    scrub_req = 1'b0;
    repeat (9) tick();
    #1;
    check("mid_scrub_busy", 32'(scrub_busy), 32'd1);
    rst_n = 1'b0;
    set_rd(0, 6'd1);
    set_rd(1, 6'd40);
    set_rd(2, 6'd63);
    #1;
    check("rst_mid_busy", 32'(scrub_busy), 32'd0);
    check("rst_mid_done", 32'(scrub_done), 32'd0);
    check("rst_mid_x1", rd(0), 32'd0);
    check("rst_mid_x40", rd(1), 32'd0);
    check("rst_mid_x63", rd(2), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("post_rst_done_%0d", c), 32'(scrub_done), 32'd0);
      check($sformatf("post_rst_busy_%0d", c), 32'(scrub_busy), 32'd0);
    end
    check("post_rst_x40", rd(1), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
